// File: rtl/tog_event_decoder.sv
// -----------------------------------------------------------------------------
// tog_event_decoder
// Receiving end of a toggle-encoded event link. Each level change on tog_in
// (driven by a remote T flip-flop) becomes one event. Events are queued in a
// saturating pending counter and handed out one at a time over valid/ready.
// A wrapping total event count and a sticky overflow flag are also kept.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on tog_in (legal 2..4)
//   CNT_W        pending counter width, queue depth 2^CNT_W-1
//   TOTAL_W      total event counter width
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   tog_in     in   toggle-encoded event line, asynchronous to clk
//   evt_valid  out  at least one event pending
//   evt_ready  in   consumer takes one event when evt_valid=1
//   pending    out  number of queued events
//   overflow   out  sticky: an event was dropped on a full queue
//   clr_ovf    in   synchronous clear of overflow (a same-cycle drop wins)
//   evt_pulse  out  one-cycle pulse per detected event (optional)
//   total_cnt  out  count of all detected events, wraps
//
// Optional feature macro: TOG_EVENT_DECODER_PULSE_OUT_EN
//   defined     -> evt_pulse port and its flop are built
//   not defined -> no evt_pulse port, no extra flops
// -----------------------------------------------------------------------------
module tog_event_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned TOTAL_W     = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               tog_in,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [CNT_W-1:0]   pending,
    output logic               overflow,
    input  logic               clr_ovf,
`ifdef TOG_EVENT_DECODER_PULSE_OUT_EN
    output logic               evt_pulse,
`endif
    output logic [TOTAL_W-1:0] total_cnt
);

    localparam int unsigned ARM_W = 3;

    localparam logic [ARM_W-1:0] ARM_DONE  = ARM_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] PEND_FULL = '1;

    typedef enum logic [0:0] {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ARM_W-1:0]         r_arm_cnt;
    logic [ARM_W-1:0]         w_arm_cnt_nxt;

    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_prev;
    logic                     w_s_out;
    logic                     w_det;
    logic                     w_pop;
    logic                     w_drop;

    logic [CNT_W-1:0]         r_pending;
    logic [CNT_W-1:0]         w_pending_nxt;
    logic                     r_valid;
    logic                     r_overflow;
    logic                     w_overflow_nxt;
    logic [TOTAL_W-1:0]       r_total;
    logic [TOTAL_W-1:0]       w_total_nxt;

    // Synchronizer chain and previous-level register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tog_in};
            r_prev <= w_s_out;
        end
    end

    assign w_s_out = r_sync[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_ARM;
            r_arm_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_arm_cnt <= w_arm_cnt_nxt;
        end
    end

    // ARM waits until the post-reset sender level has reached prev, so the
    // first s_out/prev mismatch after reset never turns into an event.
    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        case (r_state)
            ST_ARM: begin
                if (r_arm_cnt == ARM_DONE) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_arm_cnt_nxt = r_arm_cnt + ARM_W'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_ARM;
            end
        endcase
    end

    assign w_det = (w_s_out ^ r_prev) & (r_state == ST_RUN);
    assign w_pop = r_valid & evt_ready;

    // Pending / overflow / total next-state
    always_comb begin
        w_pending_nxt  = r_pending;
        w_drop         = 1'b0;
        w_total_nxt    = r_total;
        w_overflow_nxt = r_overflow;

        if (w_det) begin
            w_total_nxt = r_total + TOTAL_W'(1);
        end

        // det & pop cancel out, so a full queue never drops in that case
        if (w_det && !w_pop) begin
            if (r_pending == PEND_FULL) begin
                w_drop = 1'b1;
            end else begin
                w_pending_nxt = r_pending + CNT_W'(1);
            end
        end else if (!w_det && w_pop) begin
            w_pending_nxt = r_pending - CNT_W'(1);
        end

        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end else if (clr_ovf) begin
            w_overflow_nxt = 1'b0;
        end
    end

    // Event bookkeeping registers; valid is precomputed from next pending
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending  <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_total    <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_valid    <= (w_pending_nxt != '0);
            r_overflow <= w_overflow_nxt;
            r_total    <= w_total_nxt;
        end
    end

`ifdef TOG_EVENT_DECODER_PULSE_OUT_EN
    logic r_pulse;

    // Registered copy of det, aligned with the pending update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= w_det;
        end
    end

    assign evt_pulse = r_pulse;
`endif

    assign evt_valid = r_valid;
    assign pending   = r_pending;
    assign overflow  = r_overflow;
    assign total_cnt = r_total;

endmodule

// File: doc/tog_event_decoder.md
Name: tog_event_decoder

Overview:
- Receiving end of a toggle-encoded event link. The sender is a T flip-flop that flips its output once per event; this block turns each level change back into one discrete event.
- Synchronises the incoming toggle level, detects each transition, and queues events in a saturating pending counter.
- Delivers events to the consumer one at a time over a valid/ready handshake.
- Also keeps a free-running total event count and a sticky overflow flag.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on tog_in (legal range 2..4)
CNT_W, 4, pending counter width; queue depth is 2^CNT_W-1 events
TOTAL_W, 16, total event counter width

Ports:
clk  input  1  clock; all flops on rising edge
rstn  input  1  asynchronous active-low reset
tog_in  input  1  toggle-encoded event line; asynchronous to clk; one level change = one event
evt_valid  output  1  at least one event pending
evt_ready  input  1  consumer accepts one event when evt_valid=1
pending  output  CNT_W  number of queued events
overflow  output  1  sticky: an event was dropped because the queue was full
clr_ovf  input  1  synchronous clear of overflow
total_cnt  output  TOTAL_W  count of all detected events, wraps modulo 2^TOTAL_W

Behaviour:
- Reset (rstn=0, asynchronous): synchronizer chain=0, prev=0, state=ARM, arm counter=0, pending=0, overflow=0, total_cnt=0. Consequently evt_valid=0.
- Reset mid-operation: all queued events and counts are discarded immediately. No event is reported for the reset edge itself.
- Synchronizer:
  - SYNC_STAGES-flop chain on tog_in; s_out is the last stage.
  - prev is a register that loads s_out every cycle.
  - det = (s_out ^ prev) and (state == RUN).
- State machine:
  - ARM: prev tracks s_out, det is forced to 0, arm counter increments each cycle. When it reaches SYNC_STAGES, move to RUN. This stops the sender's post-reset level from producing a spurious event.
  - RUN: normal operation. Leaves RUN only on reset.
- Latency: a level change on tog_in captured at rising edge k makes det=1 during cycle k+SYNC_STAGES-1. pending and total_cnt update at edge k+SYNC_STAGES, and evt_valid is high from that edge on.
- evt_valid = (pending != 0), decoded from a register with no combinational input path.
  - pop = evt_valid & evt_ready.
  - evt_ready while evt_valid=0 has no effect.
- Pending update, per cycle:
  - det & !pop: pending+1. If pending is already 2^CNT_W-1 (full), pending holds, the event is dropped, and overflow sets.
  - !det & pop: pending-1.
  - det & pop: pending unchanged, including when full; no drop.
  - neither: hold.
- total_cnt increments on every det, including dropped events. It wraps from all-ones to 0 with no flag.
- overflow: set on a drop, cleared by clr_ovf. If a drop and clr_ovf happen in the same cycle, overflow = 1 (set wins).
- Two tog_in changes inside one sample window merge and are lost; this is a sender-side spacing rule. The sender must keep at least SYNC_STAGES+1 clk cycles between toggles.

Optional Feature:
Macro TOG_EVENT_DECODER_PULSE_OUT_EN.
- Defined: adds output port evt_pulse (1 bit). It is a registered copy of det: high for exactly one cycle, at the same edge where pending updates, for every detected event, including dropped ones. It is independent of the handshake.
- Not defined: the port does not exist and no extra flops are built. All other behaviour is identical.

Test Plan:
- Reset release with tog_in=1 held, run 20 cycles -> evt_valid=0, pending=0, total_cnt=0 (ARM suppresses the spurious event).
- In RUN, evt_ready=0, toggle tog_in 3 times spaced 5 cycles apart -> pending=3, total_cnt=3, evt_valid=1. First increment lands SYNC_STAGES edges after the first capture edge (2 with defaults).
- pending=3, evt_ready=1 held, no toggles -> pending steps 3,2,1,0 on consecutive edges, then evt_valid=0.
- evt_ready=0, 16 toggles with defaults (depth 15) -> pending=15, overflow=1, total_cnt=16. Pulse clr_ovf -> overflow=0 and pending stays 15.
- pending=15, evt_ready=1 in the same cycle a toggle is detected -> pending stays 15, overflow stays 0, total_cnt+1.
- Assert rstn low mid-stream with pending=5 -> pending, total_cnt and overflow go to 0 at once. With TOG_EVENT_DECODER_PULSE_OUT_EN defined, a single toggle gives exactly one evt_pulse cycle.
